// File: rtl/peres_alu_pkg.sv
// Shared definitions for the Peres ALU sharing controller: opcode encodings,
// controller FSM state type and the default operand width.
package peres_alu_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [1:0] OP_P   = 2'b00;
  localparam logic [1:0] OP_Q   = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/peres_share_ctrl_if.sv
// Request/response bus between the two ALU front-end requesters, the
// response consumer and peres_share_ctrl.
//   master: requester/consumer side (drives valids, opcodes, operands, rsp_ready)
//   slave : controller side (drives readies and the response channel)
interface peres_share_ctrl_if
  import peres_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n     : clock, asynchronous active-low reset (pointer -> 0)
//   req0, req1     : request lines
//   advance        : a grant was consumed this cycle; move the pointer
//   grant0, grant1 : one-hot (or zero) grant, combinational from requests
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic grant0,
  output logic grant1
);

  // ptr = 0 favours requester 0, ptr = 1 favours requester 1
  logic ptr;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!ptr) begin
      grant0 = req0;
      grant1 = req1 & ~req0;
    end else begin
      grant1 = req1;
      grant0 = req0 & ~req1;
    end
  end

  // After a grant the other requester becomes favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (advance) ptr <= grant0;
  end

endmodule

// File: rtl/peres_share_ctrl.sv
// Shares one registered modified_Peres datapath between two requesters:
// round-robin grant, operand issue, latency wait, P/Q/R selection and a
// valid/ready response tagged with the requester id.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus               : requester and response channels (slave modport)
//   dp_a, dp_b        : registered operands to the datapath
//   dp_issue          : one-cycle pulse when new operands are first driven
//   dp_p, dp_q, dp_r  : datapath results
//   busy              : controller not idle
//   op_count          : completed responses, wrapping
module peres_share_ctrl
  import peres_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DP_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  peres_share_ctrl_if.slave bus,
  output logic [WIDTH-1:0]  dp_a,
  output logic [WIDTH-1:0]  dp_b,
  output logic              dp_issue,
  input  logic [WIDTH-1:0]  dp_p,
  input  logic [WIDTH-1:0]  dp_q,
  input  logic [WIDTH-1:0]  dp_r,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  // The datapath samples dp_a/dp_b one edge after they are registered, so the
  // wait covers DP_LAT plus that sampling edge.
  localparam logic [3:0] CNT_LOAD = 4'(DP_LAT + 1);

  state_t     state, state_next;
  logic [3:0] cnt;
  logic [1:0] op_q;
  logic       id_q;
  logic       grant0, grant1;
  logic       accept;
  logic       cnt_zero;
  logic       rsp_fire;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (bus.req0_valid),
    .req1    (bus.req1_valid),
    .advance (accept),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  // rst_n gating keeps the readies low while reset is asserted.
  assign bus.req0_ready = rst_n & (state == IDLE) & grant0;
  assign bus.req1_ready = rst_n & (state == IDLE) & grant1;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    cnt_zero   = (cnt == '0);
    rsp_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant0 | grant1) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero) state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a         <= '0;
      dp_b         <= '0;
      dp_issue     <= 1'b0;
      cnt          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      op_count     <= '0;
    end else begin
      dp_issue <= accept;
      if (accept) begin
        dp_a <= grant0 ? bus.req0_a  : bus.req1_a;
        dp_b <= grant0 ? bus.req0_b  : bus.req1_b;
        op_q <= grant0 ? bus.req0_op : bus.req1_op;
        id_q <= grant1;
        cnt  <= CNT_LOAD;
      end else if (state == WAIT && !cnt_zero) begin
        cnt <= cnt - 4'd1;
      end

      if (state == WAIT && cnt_zero) begin
        case (op_q)
          OP_P:    bus.rsp_data <= dp_p;
          OP_Q:    bus.rsp_data <= dp_q;
          OP_R:    bus.rsp_data <= dp_r;
          default: bus.rsp_data <= '0;
        endcase
        bus.rsp_err   <= (op_q == OP_RSV);
        bus.rsp_id    <= id_q;
        bus.rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
        bus.rsp_valid <= 1'b0;
        bus.rsp_err   <= 1'b0;
        op_count      <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_peres_share_ctrl.sv
module tb_peres_share_ctrl;
  import peres_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  peres_share_ctrl_if #(.WIDTH(32)) ifa ();
  peres_share_ctrl_if #(.WIDTH(32)) ifb ();

  logic [31:0] dpa_a, dpa_b, dpa_p, dpa_q, dpa_r;
  logic        dpa_issue, busy_a;
  logic [15:0] cnt_a;

  logic [31:0] dpb_a, dpb_b, dpb_p, dpb_q, dpb_r;
  logic        dpb_issue, busy_b;
  logic [3:0]  cnt_b;

  peres_share_ctrl #(.WIDTH(32), .DP_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .dp_a(dpa_a), .dp_b(dpa_b), .dp_issue(dpa_issue),
    .dp_p(dpa_p), .dp_q(dpa_q), .dp_r(dpa_r),
    .busy(busy_a), .op_count(cnt_a)
  );

  peres_share_ctrl #(.WIDTH(32), .DP_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .dp_a(dpb_a), .dp_b(dpb_b), .dp_issue(dpb_issue),
    .dp_p(dpb_p), .dp_q(dpb_q), .dp_r(dpb_r),
    .busy(busy_b), .op_count(cnt_b)
  );

  // Datapath stand-ins: P=A, Q=A^B, R=A&B with 1 and 3 register stages.
  always_ff @(posedge clk) begin
    dpa_p <= dpa_a;
    dpa_q <= dpa_a ^ dpa_b;
    dpa_r <= dpa_a & dpa_b;
  end

  logic [31:0] pb [3];
  logic [31:0] qb [3];
  logic [31:0] rb [3];
  always_ff @(posedge clk) begin
    pb[0] <= dpb_a;         pb[1] <= pb[0]; pb[2] <= pb[1];
    qb[0] <= dpb_a ^ dpb_b; qb[1] <= qb[0]; qb[2] <= qb[1];
    rb[0] <= dpb_a & dpb_b; rb[1] <= rb[0]; rb[2] <= rb[1];
  end
  assign dpb_p = pb[2];
  assign dpb_q = qb[2];
  assign dpb_r = rb[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One operation on dut_a with DP_LAT=1 and rsp_ready already high.
  task automatic op_a(input logic exp_id, input logic [31:0] exp_a,
                      input logic [31:0] exp_data, input logic exp_err,
                      input logic [15:0] exp_cnt, input logic keep);
    #1;
    chk("ready0_idle", 32'(ifa.req0_ready), 32'(!exp_id));
    chk("ready1_idle", 32'(ifa.req1_ready), 32'(exp_id));
    tick();
    chk("dp_issue_first", 32'(dpa_issue), 32'd1);
    chk("dp_a", dpa_a, exp_a);
    chk("busy_wait", 32'(busy_a), 32'd1);
    chk("ready_low_wait", 32'(ifa.req0_ready | ifa.req1_ready), 32'd0);
    if (!keep) begin
      ifa.req0_valid = 1'b0;
      ifa.req1_valid = 1'b0;
    end
    tick();
    chk("dp_issue_second", 32'(dpa_issue), 32'd0);
    tick();
    chk("rsp_valid_early", 32'(ifa.rsp_valid), 32'd0);
    tick();
    chk("rsp_valid", 32'(ifa.rsp_valid), 32'd1);
    chk("rsp_id", 32'(ifa.rsp_id), 32'(exp_id));
    chk("rsp_data", ifa.rsp_data, exp_data);
    chk("rsp_err", 32'(ifa.rsp_err), 32'(exp_err));
    tick();
    chk("rsp_valid_done", 32'(ifa.rsp_valid), 32'd0);
    chk("busy_done", 32'(busy_a), 32'd0);
    chk("op_count", 32'(cnt_a), 32'(exp_cnt));
  endtask

  initial begin
    int          n;
    logic [31:0] b_a;

    ifa.req0_valid = 1'b0; ifa.req0_op = OP_P; ifa.req0_a = '0; ifa.req0_b = '0;
    ifa.req1_valid = 1'b0; ifa.req1_op = OP_P; ifa.req1_a = '0; ifa.req1_b = '0;
    ifa.rsp_ready  = 1'b0;
    ifb.req0_valid = 1'b0; ifb.req0_op = OP_P; ifb.req0_a = '0; ifb.req0_b = '0;
    ifb.req1_valid = 1'b0; ifb.req1_op = OP_P; ifb.req1_a = '0; ifb.req1_b = '0;
    ifb.rsp_ready  = 1'b0;

    // Reset state, with a request pending to prove ready is held low
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    ifa.req0_valid = 1'b1;
    #1;
    chk("rst_ready0", 32'(ifa.req0_ready), 32'd0);
    chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_dp_issue", 32'(dpa_issue), 32'd0);
    chk("rst_op_count", 32'(cnt_a), 32'd0);
    ifa.req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Single P op from requester 0
    ifa.rsp_ready  = 1'b1;
    ifa.req0_valid = 1'b1; ifa.req0_op = OP_P;
    ifa.req0_a = 32'hA5A5A5A5; ifa.req0_b = 32'h5A5A5A5A;
    #1;
    chk("t1_dp_b_before", dpa_b, 32'h0);
    op_a(1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 16'd1, 1'b0);
    chk("t1_dp_b", dpa_b, 32'h5A5A5A5A);

    // Reserved opcode from requester 1
    ifa.req1_valid = 1'b1; ifa.req1_op = OP_RSV;
    ifa.req1_a = 32'h0F0F0F0F; ifa.req1_b = 32'hF0F0F0F0;
    op_a(1'b1, 32'h0F0F0F0F, 32'h00000000, 1'b1, 16'd2, 1'b0);

    // Both requesting continuously: grants alternate 0,1,0,1
    ifa.req0_valid = 1'b1; ifa.req0_op = OP_Q;
    ifa.req0_a = 32'hFFFFFFFF; ifa.req0_b = 32'h00000000;
    ifa.req1_valid = 1'b1; ifa.req1_op = OP_R;
    ifa.req1_a = 32'h12345678; ifa.req1_b = 32'h87654321;
    op_a(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 16'd3, 1'b1);
    op_a(1'b1, 32'h12345678, 32'h02244220, 1'b0, 16'd4, 1'b1);
    op_a(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 16'd5, 1'b1);
    op_a(1'b1, 32'h12345678, 32'h02244220, 1'b0, 16'd6, 1'b1);
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;

    // Back-pressure: rsp_ready low for 5 cycles in RESP
    ifa.rsp_ready  = 1'b0;
    ifa.req0_valid = 1'b1; ifa.req0_op = OP_P;
    ifa.req0_a = 32'h3C3C3C3C; ifa.req0_b = 32'h0;
    #1;
    chk("hold_ready0", 32'(ifa.req0_ready), 32'd1);
    tick();
    ifa.req0_valid = 1'b0;
    ifa.req0_a     = 32'hDEADBEEF;
    ifa.req1_valid = 1'b1; ifa.req1_op = OP_P;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(ifa.rsp_valid), 32'd1);
      chk("hold_rsp_data", ifa.rsp_data, 32'h3C3C3C3C);
      chk("hold_ready0", 32'(ifa.req0_ready), 32'd0);
      chk("hold_ready1", 32'(ifa.req1_ready), 32'd0);
      chk("hold_dp_a", dpa_a, 32'h3C3C3C3C);
      tick();
    end
    ifa.req1_valid = 1'b0;
    ifa.rsp_ready  = 1'b1;
    tick();
    chk("hold_busy_after", 32'(busy_a), 32'd0);
    chk("hold_rsp_valid_after", 32'(ifa.rsp_valid), 32'd0);
    chk("hold_op_count", 32'(cnt_a), 32'd7);

    // Reset during WAIT: pointer would favour requester 1 without the reset
    ifa.req0_valid = 1'b1; ifa.req0_op = OP_P;
    ifa.req0_a = 32'h22222222; ifa.req0_b = 32'h0;
    tick();
    ifa.req0_valid = 1'b0;
    chk("rstw_dp_issue_pre", 32'(dpa_issue), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_dp_issue", 32'(dpa_issue), 32'd0);
    chk("rstw_busy", 32'(busy_a), 32'd0);
    chk("rstw_dp_a", dpa_a, 32'h0);
    chk("rstw_op_count", 32'(cnt_a), 32'd0);
    chk("rstw_rsp_data", ifa.rsp_data, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstw_no_rsp", 32'(ifa.rsp_valid), 32'd0);
      chk("rstw_idle", 32'(busy_a), 32'd0);
    end
    ifa.req0_valid = 1'b1;
    ifa.req1_valid = 1'b1;
    #1;
    chk("rstw_grant0", 32'(ifa.req0_ready), 32'd1);
    chk("rstw_grant1", 32'(ifa.req1_ready), 32'd0);
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;
    tick();

    // dut_b: DP_LAT=3 latency and 4-bit op_count wrap over 16 ops
    ifb.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_a = 32'(i) * 32'h01010101 + 32'h00000010;
      ifb.req0_valid = 1'b1; ifb.req0_op = OP_P;
      ifb.req0_a = b_a; ifb.req0_b = ~b_a;
      #1;
      chk("b_ready0", 32'(ifb.req0_ready), 32'd1);
      tick();
      ifb.req0_valid = 1'b0;
      n = 0;
      while (ifb.rsp_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("b_latency", 32'(n), 32'd5);
      chk("b_rsp_data", ifb.rsp_data, b_a);
      tick();
      chk("b_op_count", 32'(cnt_b), 32'((i + 1) % 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
